regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, at least 2.
REQ-003 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-004 SHALL derive localparam AW = clog2(NREG), the address width.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports rs1, rs2  input  AW  read addresses.
REQ-008 SHALL have ports rd1, rd2  output  XLEN  combinational read data.
REQ-009 SHALL have ports rs1_busy, rs2_busy  output  1  combinational scoreboard status of rs1 and rs2.
REQ-010 SHALL have port wr_en  input  1  writeback strobe.
REQ-011 SHALL have port wr_addr  input  AW  writeback register address.
REQ-012 SHALL have port wr_data  input  XLEN  writeback data.
REQ-013 SHALL have port issue_en  input  1  marks a destination as pending.
REQ-014 SHALL have port issue_rd  input  AW  register being issued.
REQ-015 SHALL have port flush  input  1  clears all pending marks.
REQ-016 SHALL have port busy_cnt  output  AW+1  registered count of busy registers.

Function
REQ-017 SHALL hold NREG x XLEN storage and an NREG-bit busy vector.
REQ-018 Register 0 SHALL read as 0 and report busy 0 at all times; writes and issues to it are ignored.
REQ-019 With wr_en=1 and wr_addr!=0, the rising edge SHALL store wr_data and clear that register's busy bit.
REQ-020 With issue_en=1 and issue_rd!=0, the rising edge SHALL set that register's busy bit.
REQ-021 If issue and write target the same register on one edge, data SHALL be stored and busy SHALL end at 1 (issue wins).
REQ-022 With flush=1, the edge SHALL clear all busy bits; a concurrent issue SHALL still set its bit, and a concurrent write SHALL still store data.
REQ-023 Reads SHALL be combinational from the current storage, with zero cycles of latency.
REQ-024 When BYPASS=1, wr_en=1, wr_addr!=0 and rsN==wr_addr, rdN SHALL equal wr_data and rsN_busy SHALL be 0 in the same cycle.
REQ-025 When BYPASS=0, reads SHALL return pre-edge storage and busy state; the new value is visible the cycle after the write.
REQ-026 busy_cnt SHALL equal the popcount of the busy vector after each edge, with no extra latency.
REQ-027 busy_cnt SHALL NOT overflow; its maximum is NREG-1.
REQ-028 Issuing an already-busy register SHALL leave it busy and SHALL NOT increment busy_cnt.
REQ-029 Writing a non-busy register SHALL store data, SHALL leave busy at 0, and SHALL NOT decrement busy_cnt.

Reset
REQ-030 rst=0 SHALL immediately, without waiting for clk, clear all storage to 0, all busy bits to 0 and busy_cnt to 0.
REQ-031 While rst=0, writes, issues and flushes SHALL be ignored; outputs SHALL reflect the cleared state (rd1/rd2 = 0, busy = 0).
REQ-032 Release of rst SHALL take effect so that the first rising edge after release performs normal updates.
REQ-033 Asserting rst between edges while registers are busy SHALL discard all pending state with no partial update.

Verification
REQ-034 Reset, then read all addresses -> rd1=rd2=0, busy=0, busy_cnt=0.
REQ-035 Write 0xDEADBEEF to r5, next cycle rs1=5 -> rd1=0xDEADBEEF; write 0x1234 to r0, then rs2=0 -> rd2=0.
REQ-036 Issue r3 and r7, then issue r3 again -> busy_cnt=2; write r3 -> busy_cnt=1 and rs1_busy(rs1=3)=0.
REQ-037 BYPASS=1: wr_en, wr_addr=9, wr_data=0xA5A5A5A5, rs1=9 in the same cycle -> rd1=0xA5A5A5A5 and rs1_busy=0; BYPASS=0: rd1=old value.
REQ-038 Same edge: issue r4 and write r4=0x55 -> r4 reads 0x55 and busy=1; flush plus issue r6 with r2,r4 busy -> only r6 busy, busy_cnt=1.
REQ-039 Issue all NREG-1 non-zero registers -> busy_cnt=NREG-1; assert rst mid-cycle -> busy_cnt=0 and all busy=0 before the next edge.

Source files
------------

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- register file with an integrated busy scoreboard
//
// Holds NREG x XLEN data registers plus one busy bit per register. Register 0
// is hardwired to zero and is never busy. Issue marks a destination busy,
// writeback stores data and clears the busy bit (issue wins on a collision),
// and flush clears every pending mark. Reads are combinational; with BYPASS=1
// a same-cycle writeback is forwarded to a matching read port.
//
// Ports
//   clk       in   1      clock, all state updates on its rising edge
//   rst       in   1      asynchronous active-low reset
//   rs1, rs2  in   AW     read addresses
//   rd1, rd2  out  XLEN   combinational read data
//   rs1_busy  out  1      combinational busy status of rs1
//   rs2_busy  out  1      combinational busy status of rs2
//   wr_en     in   1      writeback strobe
//   wr_addr   in   AW     writeback register address
//   wr_data   in   XLEN   writeback data
//   issue_en  in   1      marks issue_rd as pending
//   issue_rd  in   AW     register being issued
//   flush     in   1      clears all pending marks
//   busy_cnt  out  AW+1   registered popcount of the busy vector
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  output logic [XLEN-1:0]          rd1,
  output logic [XLEN-1:0]          rd2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  input  logic                     wr_en,
  input  logic [$clog2(NREG)-1:0]  wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     issue_en,
  input  logic [$clog2(NREG)-1:0]  issue_rd,
  input  logic                     flush,
  output logic [$clog2(NREG):0]    busy_cnt
);

  localparam int AW = $clog2(NREG);
  localparam bit BYP_EN = (BYPASS == 1);

  // Population count of a busy vector; bit 0 is always clear so the result
  // never exceeds NREG-1 and fits in AW+1 bits.
  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;
  logic            wr_ok_s;
  logic            iss_ok_s;

  assign wr_ok_s  = wr_en    && (wr_addr  != {AW{1'b0}});
  assign iss_ok_s = issue_en && (issue_rd != {AW{1'b0}});

  // Busy-vector next state: flush first, then writeback clear, then issue set
  // so that issue wins over both flush and a same-register writeback.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = {NREG{1'b0}};
    end else begin
      busy_d = busy_q;
    end
    if (wr_ok_s) begin
      busy_d[wr_addr] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_ok_s) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
    // Count the post-edge vector so busy_cnt tracks busy_q with no lag.
    cnt_d = popcount(busy_d);
  end

  // Data storage; register 0 is never written and stays at its reset zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {XLEN{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Scoreboard state and its registered popcount.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= {NREG{1'b0}};
      cnt_q  <= {(AW+1){1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // Read port 1. Forwarding is gated by rst so the cleared state is what
  // appears on the outputs while reset is held.
  always_comb begin
    rd1      = mem_q[rs1];
    rs1_busy = busy_q[rs1];
    if (rs1 == {AW{1'b0}}) begin
      rd1      = {XLEN{1'b0}};
      rs1_busy = 1'b0;
    end else if (BYP_EN && rst && wr_ok_s && (wr_addr == rs1)) begin
      rd1      = wr_data;
      rs1_busy = 1'b0;
    end else begin
      rd1      = mem_q[rs1];
      rs1_busy = busy_q[rs1];
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    rd2      = mem_q[rs2];
    rs2_busy = busy_q[rs2];
    if (rs2 == {AW{1'b0}}) begin
      rd2      = {XLEN{1'b0}};
      rs2_busy = 1'b0;
    end else if (BYP_EN && rst && wr_ok_s && (wr_addr == rs2)) begin
      rd2      = wr_data;
      rs2_busy = 1'b0;
    end else begin
      rd2      = mem_q[rs2];
      rs2_busy = busy_q[rs2];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- directed self-checking bench for regfile_sb
//
// Two instances share all inputs: byp (BYPASS=1) and nby (BYPASS=0). Inputs
// change #1 after a rising edge; combinational outputs are sampled a further
// #1 later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1, rs2, wr_addr, issue_rd;
  logic [XLEN-1:0] wr_data;
  logic            wr_en, issue_en, flush;

  logic [XLEN-1:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic            b_bz1, b_bz2, n_bz1, n_bz2;
  logic [AW:0]     b_cnt, n_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .rd1(b_rd1), .rd2(b_rd2), .rs1_busy(b_bz1), .rs2_busy(b_bz2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .busy_cnt(b_cnt)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_nby (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .rd1(n_rd1), .rd2(n_rd2), .rs1_busy(n_bz1), .rs2_busy(n_bz2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .busy_cnt(n_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    wr_addr = '0; issue_rd = '0; wr_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    rs1 = '0; rs2 = '0;
    idle();
    #1 rst = 1'b0;
    #1;

    // Reset state on every address, both instances.
    for (int i = 0; i < NREG; i++) begin
      rs1 = AW'(i); rs2 = AW'(NREG - 1 - i);
      #1;
      if ((b_rd1 | b_rd2 | n_rd1 | n_rd2) != 32'h0) check("rst_rd", {b_rd1 | b_rd2, n_rd1 | n_rd2}, 64'h0);
      if ((b_bz1 | b_bz2 | n_bz1 | n_bz2) != 1'b0)  check("rst_busy", {b_bz1, b_bz2, n_bz1, n_bz2}, 64'h0);
    end
    check("rst_rd1", b_rd1, 64'h0);
    check("rst_cnt", b_cnt, 64'h0);
    check("rst_cnt_nby", n_cnt, 64'h0);

    @(negedge clk);
    rst = 1'b1;
    tick();

    // Write r5, read next cycle; write r0 is ignored.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle(); rs1 = 5'd5;
    #1;
    check("r5_byp", b_rd1, 64'hDEADBEEF);
    check("r5_nby", n_rd1, 64'hDEADBEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    issue_en = 1'b1; issue_rd = 5'd0;
    tick();
    idle(); rs2 = 5'd0;
    #1;
    check("r0_rd", b_rd2, 64'h0);
    check("r0_busy", b_bz2, 64'h0);
    check("r0_cnt", b_cnt, 64'h0);

    // Issue r3, r7, r3 again.
    issue_en = 1'b1; issue_rd = 5'd3; tick();
    issue_rd = 5'd7; tick();
    issue_rd = 5'd3; tick();
    idle(); rs1 = 5'd3;
    #1;
    check("iss_cnt", b_cnt, 64'd2);
    check("iss_busy3", b_bz1, 64'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    idle();
    #1;
    check("wb_cnt", b_cnt, 64'd1);
    check("wb_busy3", b_bz1, 64'd0);
    check("wb_rd3", b_rd1, 64'h33);

    // Forwarding: r9 busy, then written while read in the same cycle.
    issue_en = 1'b1; issue_rd = 5'd9; tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; rs1 = 5'd9;
    #1;
    check("byp_rd1", b_rd1, 64'hA5A5A5A5);
    check("byp_busy", b_bz1, 64'd0);
    check("nby_rd1", n_rd1, 64'h0);
    check("nby_busy", n_bz1, 64'd1);
    tick();
    idle();
    #1;
    check("nby_rd1_next", n_rd1, 64'hA5A5A5A5);
    check("nby_busy_next", n_bz1, 64'd0);
    check("cnt_r7", n_cnt, 64'd1);

    // Issue and write r4 on the same edge: data stored, issue wins.
    issue_en = 1'b1; issue_rd = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    tick();
    idle(); rs1 = 5'd4;
    #1;
    check("coll_rd4", b_rd1, 64'h55);
    check("coll_busy4", b_bz1, 64'd1);
    check("coll_cnt", b_cnt, 64'd2);
    issue_en = 1'b1; issue_rd = 5'd2; tick();
    idle();
    #1;
    check("pre_flush_cnt", b_cnt, 64'd3);

    // Flush with concurrent issue of r6.
    flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd6;
    tick();
    idle(); rs1 = 5'd2; rs2 = 5'd6;
    #1;
    check("fl_cnt", b_cnt, 64'd1);
    check("fl_busy2", b_bz1, 64'd0);
    check("fl_busy6", b_bz2, 64'd1);

    // Flush with concurrent write still stores data.
    flush = 1'b1; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h77;
    tick();
    idle(); rs1 = 5'd10;
    #1;
    check("flw_rd10", n_rd1, 64'h77);
    check("flw_cnt", b_cnt, 64'd0);

    // Writing a non-busy register leaves the count alone.
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hCAFE;
    tick();
    idle(); rs1 = 5'd11;
    #1;
    check("nb_rd11", b_rd1, 64'hCAFE);
    check("nb_busy11", b_bz1, 64'd0);
    check("nb_cnt", b_cnt, 64'd0);

    // Issue every register including r0 (ignored): count saturates at NREG-1.
    for (int i = 0; i < NREG; i++) begin
      issue_en = 1'b1; issue_rd = AW'(i);
      tick();
    end
    idle(); rs1 = 5'd31; rs2 = 5'd0;
    #1;
    check("all_cnt", b_cnt, 64'd31);
    check("all_busy31", b_bz1, 64'd1);
    check("all_busy0", b_bz2, 64'd0);

    // Mid-cycle reset: cleared before the next edge.
    #1 rst = 1'b0;
    #1;
    check("mid_cnt", b_cnt, 64'd0);
    check("mid_busy31", b_bz1, 64'd0);
    rs1 = 5'd5;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111;
    #1;
    check("mid_rd5", b_rd1, 64'h0);
    issue_en = 1'b1; issue_rd = 5'd8;
    tick();
    #1;
    check("rst_hold_rd5", b_rd1, 64'h0);
    check("rst_hold_cnt", b_cnt, 64'd0);

    // First edge after release performs a normal update.
    @(negedge clk);
    rst = 1'b1;
    idle();
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h99;
    issue_en = 1'b1; issue_rd = 5'd13;
    tick();
    idle(); rs1 = 5'd12; rs2 = 5'd13;
    #1;
    check("rel_rd12", n_rd1, 64'h99);
    check("rel_busy13", n_bz2, 64'd1);
    check("rel_cnt", n_cnt, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
